// File: rtl/ula_muldiv_seq.sv
// ula_muldiv_seq: iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO.
// Define ULA_MDU_DIV_EN to build the divide datapath; otherwise DIV/DIVU decode as illegal.
module ula_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             flush,
  input  logic [3:0]       ALUOp,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic             divzero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             div_q, neg_q, rneg_q, dz_q;
  logic [WIDTH-1:0] bm_q, acc_q, sh_q, hi_q, lo_q;
  logic             busy_q, done_q, illegal_q, divzero_q;
  logic             r_type, is_mul, is_div, is_mthi, is_mtlo, sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b, mul_acc, mul_sh, div_acc, div_sh, quo, rem, hi_d, lo_d;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH-1:0] prod, prod_f;
`ifdef ULA_MDU_DIV_EN
  localparam bit DivEn = 1'b1;
  logic [WIDTH:0]   div_t;
  logic [WIDTH-1:0] div_sub;
  logic             div_ge;
  // Restoring step: remainder is always below the divisor, so W bits hold it.
  always_comb begin
    div_t   = {acc_q, sh_q[WIDTH-1]};
    div_ge  = div_t >= {1'b0, bm_q};
    div_sub = div_t[WIDTH-1:0] - bm_q;
    div_acc = div_ge ? div_sub : div_t[WIDTH-1:0];
    div_sh  = {sh_q[WIDTH-2:0], div_ge};
  end
`else
  localparam bit DivEn = 1'b0;
  assign div_acc = '0;
  assign div_sh  = '0;
`endif
  always_comb begin
    r_type  = ALUOp == 4'd2;
    is_mul  = r_type && func[5:1] == 5'b01100;
    is_div  = DivEn && r_type && func[5:1] == 5'b01101;
    is_mthi = r_type && func == 6'b010001;
    is_mtlo = r_type && func == 6'b010011;
    sa      = ~func[0] & a[WIDTH-1];
    sb      = ~func[0] & b[WIDTH-1];
    mag_a   = sa ? -a : a;
    mag_b   = sb ? -b : b;
    mul_sum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, bm_q} : '0);
    mul_acc = mul_sum[WIDTH:1];
    mul_sh  = {mul_sum[0], sh_q[WIDTH-1:1]};
    prod    = {acc_q, sh_q};
    prod_f  = neg_q ? -prod : prod;
    quo     = dz_q ? '1 : (neg_q ? -sh_q : sh_q);
    rem     = rneg_q ? -acc_q : acc_q;
    hi_d    = div_q ? rem : prod_f[2*WIDTH-1:WIDTH];
    lo_d    = div_q ? quo : prod_f[WIDTH-1:0];
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      dz_q      <= 1'b0;
      bm_q      <= '0;
      acc_q     <= '0;
      sh_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      divzero_q <= 1'b0;
      if (flush) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else if (state_q == IDLE) begin
        if (start) begin
          if (is_mul || is_div) begin
            state_q <= CALC;
            busy_q  <= 1'b1;
            cnt_q   <= CW'(WIDTH - 1);
            div_q   <= is_div;
            neg_q   <= sa ^ sb;
            rneg_q  <= sa;
            dz_q    <= b == '0;
            acc_q   <= '0;
            bm_q    <= is_div ? mag_b : mag_a;
            sh_q    <= is_div ? mag_a : mag_b;
          end else if (is_mthi || is_mtlo) begin
            if (is_mthi) hi_q <= a;
            else lo_q <= a;
            done_q <= 1'b1;
          end else begin
            illegal_q <= 1'b1;
          end
        end
      end else if (state_q == CALC) begin
        acc_q <= div_q ? div_acc : mul_acc;
        sh_q  <= div_q ? div_sh : mul_sh;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == '0) state_q <= FIX;
      end else begin
        hi_q      <= hi_d;
        lo_q      <= lo_d;
        done_q    <= 1'b1;
        divzero_q <= DivEn && div_q && dz_q;
        busy_q    <= 1'b0;
        state_q   <= IDLE;
      end
    end
  end
  assign busy    = busy_q;
  assign done    = done_q;
  assign illegal = illegal_q;
  assign divzero = divzero_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
endmodule

// File: tb/tb_ula_muldiv_seq.sv
// tb_ula_muldiv_seq: random and directed checks of ula_muldiv_seq against an arithmetic reference model.
module tb_ula_muldiv_seq;
`ifdef ULA_MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  logic        clock = 1'b0, reset_n = 1'b0, start = 1'b0, flush = 1'b0;
  logic [3:0]  ALUOp = 4'd0;
  logic [5:0]  func = 6'd0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, illegal, divzero;
  logic [31:0] hi, lo;
  logic [31:0] m_hi = '0, m_lo = '0;
  int n_cmp = 0, n_bad = 0;

  ula_muldiv_seq #(.WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .flush(flush),
    .ALUOp(ALUOp), .func(func), .a(a), .b(b),
    .busy(busy), .done(done), .illegal(illegal), .divzero(divzero),
    .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // kind: 0 illegal, 1 move-to (one edge), 2 multiply/divide (multi-cycle)
  task automatic model(input logic [3:0] op, input logic [5:0] f, input logic [31:0] x, y,
                       output int kind, output logic [31:0] eh, el, output logic edz);
    longint sx, sy;
    logic [63:0] p, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    kind = 0; eh = m_hi; el = m_lo; edz = 1'b0;
    if (op == 4'd2 && (f == 6'd24 || f == 6'd25)) begin
      kind = 2;
      p = (f == 6'd24) ? 64'(sx * sy) : {32'b0, x} * {32'b0, y};
      eh = p[63:32]; el = p[31:0];
    end else if (op == 4'd2 && DIV_EN && (f == 6'd26 || f == 6'd27)) begin
      kind = 2;
      if (y == 0) begin
        el = '1; eh = x; edz = 1'b1;
      end else begin
        q = (f == 6'd26) ? 64'(sx / sy) : 64'(x / y);
        r = (f == 6'd26) ? 64'(sx % sy) : 64'(x % y);
        el = q[31:0]; eh = r[31:0];
      end
    end else if (op == 4'd2 && f == 6'd17) begin
      kind = 1; eh = x;
    end else if (op == 4'd2 && f == 6'd19) begin
      kind = 1; el = x;
    end
  endtask

  task automatic do_op(input logic [3:0] op, input logic [5:0] f, input logic [31:0] x, y, input string tag);
    int kind, n, bc;
    logic [31:0] eh, el;
    logic edz;
    model(op, f, x, y, kind, eh, el, edz);
    @(negedge clock);
    ALUOp = op; func = f; a = x; b = y; start = 1'b1;
    @(negedge clock);
    start = 1'b0; a = $urandom; b = $urandom;
    if (kind == 0) begin
      check({tag, ".illegal"}, illegal, 1);
      check({tag, ".busy"}, busy, 0);
      check({tag, ".hilo"}, {hi, lo}, {m_hi, m_lo});
      @(negedge clock);
      check({tag, ".illegal_pulse"}, illegal, 0);
    end else begin
      n = 0; bc = 0;
      while (!done && n < 80) begin
        bc += int'(busy);
        n++;
        @(negedge clock);
      end
      check({tag, ".latency"}, n, kind == 1 ? 0 : 33);
      check({tag, ".busy_cycles"}, bc, kind == 1 ? 0 : 33);
      check({tag, ".busy_at_done"}, busy, 0);
      check({tag, ".hilo"}, {hi, lo}, {eh, el});
      check({tag, ".divzero"}, divzero, edz);
      @(negedge clock);
      check({tag, ".done_pulse"}, done, 0);
      m_hi = eh; m_lo = el;
    end
  endtask

  function automatic logic [31:0] rnd_val();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h0;
      1: v = 32'h1;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h8000_0000;
      4: v = 32'h7FFF_FFFF;
      5: v = $urandom_range(0, 15);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    logic [5:0] ftab [8];
    logic [31:0] eh, el;
    logic edz;
    int kind, nd, ni;
    logic [3:0] op;
    ftab = '{6'd24, 6'd25, 6'd26, 6'd27, 6'd17, 6'd19, 6'd24, 6'd0};
    repeat (2) @(negedge clock);
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.illegal", illegal, 0);
    check("reset.divzero", divzero, 0);
    check("reset.hilo", {hi, lo}, 64'h0);
    reset_n = 1'b1;

    do_op(4'd2, 6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    do_op(4'd2, 6'd24, -32'sd3, 32'd7, "mult_neg");
    do_op(4'd2, 6'd24, 32'h8000_0000, 32'h8000_0000, "mult_min");
    do_op(4'd2, 6'd26, -32'sd7, 32'd2, "div_neg");
    do_op(4'd2, 6'd27, 32'd7, 32'd0, "divu_zero");
    do_op(4'd2, 6'd26, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    do_op(4'd2, 6'd26, -32'sd9, 32'd0, "div_zero_neg");
    do_op(4'd0, 6'd24, 32'd5, 32'd6, "aluop0");
    do_op(4'd2, 6'd17, 32'h1234, 32'd0, "mthi");
    do_op(4'd2, 6'd19, 32'h5678, 32'd0, "mtlo");
    do_op(4'd2, 6'd63, 32'd1, 32'd1, "bad_func");

    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'd2;
      func = ftab[$urandom_range(0, 7)];
      if (func == 6'd0) func = 6'($urandom);
      do_op(op, func, rnd_val(), rnd_val(), $sformatf("rnd%0d", i));
    end

    // second start while busy must be ignored
    model(4'd2, 6'd24, 32'h0001_2345, 32'hFFFF_FF00, kind, eh, el, edz);
    @(negedge clock);
    ALUOp = 4'd2; func = 6'd24; a = 32'h0001_2345; b = 32'hFFFF_FF00; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    func = 6'd17; a = 32'hDEAD; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    nd = 0; ni = int'(illegal);
    for (int i = 0; i < 45; i++) begin
      nd += int'(done);
      ni += int'(illegal);
      @(negedge clock);
    end
    check("busy_start.dones", nd, 1);
    check("busy_start.illegals", ni, 0);
    check("busy_start.hilo", {hi, lo}, {eh, el});
    m_hi = eh; m_lo = el;

    // flush mid-operation
    @(negedge clock);
    ALUOp = 4'd2; func = DIV_EN ? 6'd26 : 6'd24; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    check("flush.busy_before", busy, 1);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check("flush.busy_after", busy, 0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      nd += int'(done);
      @(negedge clock);
    end
    check("flush.dones", nd, 0);
    check("flush.hilo", {hi, lo}, {m_hi, m_lo});

    // flush in IDLE suppresses start
    ALUOp = 4'd2; func = 6'd17; a = 32'h5555; start = 1'b1; flush = 1'b1;
    @(negedge clock);
    start = 1'b0; flush = 1'b0;
    check("idle_flush.done", done, 0);
    check("idle_flush.hilo", {hi, lo}, {m_hi, m_lo});

    // asynchronous reset mid-operation
    do_op(4'd2, 6'd25, 32'hABCD_0123, 32'h0000_1111, "pre_reset");
    ALUOp = 4'd2; func = 6'd24; a = 32'd77; b = 32'd99; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (14) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset.busy", busy, 0);
    check("async_reset.hilo", {hi, lo}, 64'h0);
    check("async_reset.done", done, 0);
    m_hi = '0; m_lo = '0;
    @(negedge clock);
    reset_n = 1'b1;
    do_op(4'd2, 6'd25, 32'd3, 32'd5, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ula_muldiv_seq.md
# ula_muldiv_seq

Iterative multiply/divide unit that extends the ALU control decode with multi-cycle operations, and owns the HI/LO register pair. It sits beside the single-cycle ULA in the execute stage. It accepts R-type MULT/MULTU/DIV/DIVU/MTHI/MTLO through a start/busy/done handshake. The data width is parametrised, and HI/LO are always readable for MFHI/MFLO.

## Interface
- `WIDTH`, default 32: operand and HI/LO width; must be ≥ 4.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a new operation; sampled only in IDLE.
- `flush` input 1: abort any operation in progress.
- `ALUOp` input 4: ALUOp from the control unit; only 2 (R-type) is valid.
- `func` input 6: instruction bits [5:0].
- `a` input WIDTH: rs operand (dividend or multiplicand).
- `b` input WIDTH: rt operand (divisor or multiplier).
- `busy` output 1: an operation is in progress.
- `done` output 1: one-cycle pulse when HI/LO have just been written.
- `illegal` output 1: one-cycle pulse when a start was rejected.
- `divzero` output 1: one-cycle pulse alongside `done` when a divide had `b`=0.
- `hi` output WIDTH: HI register.
- `lo` output WIDTH: LO register.

## Operation
- **Decode** (with `ALUOp`=2):
  - `func` 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010001 MTHI, 010011 MTLO.
  - Any other `func`, or any other `ALUOp`, is illegal.
- **States**: IDLE, CALC, FIX.
- **IDLE, `start`=1, legal multiply/divide**:
  - Latch the operand magnitudes, the sign flags and the op.
  - Set counter to WIDTH−1 and go to CALC.
- **IDLE, `start`=1, MTHI/MTLO**:
  - On the same edge, `hi`←`a` (MTHI) or `lo`←`a` (MTLO).
  - `done`=1 in the next cycle; no busy; stay in IDLE.
- **IDLE, `start`=1, illegal**:
  - `illegal`=1 for one cycle.
  - No state change; HI/LO unchanged.
- **CALC**:
  - One shift-add (multiply) or restoring shift-subtract (divide) iteration per cycle.
  - Counter decrements; at counter 0, go to FIX after that iteration.
- **FIX**:
  - Apply the sign corrections and write HI/LO.
  - Pulse `done` and go to IDLE.
- **Multiply result**: 2·WIDTH product; HI = upper half, LO = lower half.
  - MULT: magnitudes are multiplied, and the product is negated in 2·WIDTH bits if the operand signs differ.
- **Divide result**: LO = quotient, HI = remainder.
  - DIV: quotient is negated if the signs differ; remainder takes the sign of the dividend (truncating division).
- **Divide by zero** (`b`=0): LO = all ones, HI = `a`, and `divzero` pulses with `done`. The full iteration count still runs.
- **Signed overflow** (DIV of most-negative value by −1): LO = most-negative value, HI = 0.
- **`start` while busy**: ignored. No `illegal`, and the request is not queued.
- **`flush`**:
  - In CALC or FIX: go to IDLE on the next edge, with no `done` and HI/LO unchanged.
  - `flush` has priority over FIX completion.
  - In IDLE it also suppresses `start`.
- **Reset**: while `reset_n`=0, all state and outputs are forced immediately to IDLE/0. This includes `hi`=`lo`=0, `busy`=`done`=`illegal`=`divzero`=0.

## Timing
- `busy` is registered: high from the edge that accepts `start` until the FIX edge; low in the cycle `done` is high.
- Latency for multiply/divide: the accepting edge is E0, iterations run on E1..E_WIDTH, and FIX is on E_WIDTH+1.
  - HI/LO are valid and `done`=1 in the cycle after E_WIDTH+1.
  - For WIDTH=32 that is 33 edges after acceptance.
- Latency for MTHI/MTLO: 1 edge.
- The earliest back-to-back `start` is accepted in the `done` cycle, giving a throughput of one op per WIDTH+2 cycles.
- `hi` and `lo` are register outputs and are stable during CALC; they hold the previous result.
- Operands `a`/`b` only need to be valid at the accepting edge.

## Configuration
- `ULA_MDU_DIV_EN` defined: DIV/DIVU are supported as described, including the `divzero` behaviour.
- `ULA_MDU_DIV_EN` undefined:
  - DIV/DIVU decode as illegal and pulse `illegal`.
  - The divide datapath is absent, and `divzero` is tied to 0.

## Test plan
All scenarios use WIDTH=32.
- MULTU `a`=0xFFFFFFFF, `b`=0xFFFFFFFF → after 33 edges, `hi`=0xFFFFFFFE, `lo`=0x00000001; `done` one cycle; `busy` high for exactly 33 cycles.
- MULT `a`=−3, `b`=7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. MULT 0x80000000 × 0x80000000 → `hi`=0x40000000, `lo`=0.
- DIV `a`=−7, `b`=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIVU `a`=7, `b`=0 → `lo`=0xFFFFFFFF, `hi`=7, `divzero`=1 with `done`.
  - DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Second `start` 5 cycles into a MULT → ignored, single `done`. `flush` at cycle 10 of a DIV → `busy`=0 next cycle, HI/LO keep their old values, no `done`.
- `ALUOp`=0 with `start` → `illegal` pulse, HI/LO unchanged. MTHI `a`=0x1234 → `hi`=0x1234 after 1 edge, `done`=1, `busy` never set.
  - Without `ULA_MDU_DIV_EN`: DIVU → `illegal`=1.
- `reset_n` low at cycle 15 of a MULT → `busy`=0 and `hi`=`lo`=0 immediately without a clock edge. After release, a new MULTU 3×5 → `lo`=15, `hi`=0.
